spi_master_mc: RTL and testbench

SPI_MASTER_MC -- requirements
Module: spi_master_mc

---
 rtl/spi_master_mc.sv | 122 ++++++++++++
 tb/tb_spi_master_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mc.sv
// SPI master: one DATA_WIDTH word per transfer with per-transfer mode, bit order and slave select.
// Settings are captured at acceptance, so input changes during a transfer have no effect.
module spi_master_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 5,
    parameter int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CSW-1:0]        cs_sel,
    input  logic [1:0]            mode,
    input  logic                  lsb_first,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  err
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW    = $clog2(2 * DATA_WIDTH);
    localparam logic [CSW:0] CS_LIM = (CSW + 1)'(NUM_CS);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [HW-1:0]         hcnt;
    logic                  cpol_lat, cpha_lat, lsb_lat;
    logic [CSW-1:0]        cs_lat;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;

    logic cs_ok, accept, reject, cnt_end, last_half;
    logic edge_tick, lead_edge, trail_edge, sample_en, shift_en, finish;

    assign cs_ok      = ({1'b0, cs_sel} < CS_LIM);
    assign accept     = (state == IDLE) && start && cs_ok;
    assign reject     = (state == IDLE) && start && !cs_ok;
    assign cnt_end    = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_half  = (hcnt == HW'(2 * DATA_WIDTH - 1));
    assign finish     = (state == HOLD) && cnt_end;

    // Even half-period indices end on a leading sclk edge, odd ones on a trailing edge.
    assign edge_tick  = (state == XFER) && cnt_end;
    assign lead_edge  = edge_tick && !hcnt[0];
    assign trail_edge = edge_tick && hcnt[0];
    assign sample_en  = cpha_lat ? trail_edge : lead_edge;
    // The first bit is already on mosi from SETUP, so the first CPHA=1 leading edge only presents it.
    assign shift_en   = cpha_lat ? (lead_edge && (hcnt != '0)) : (trail_edge && !last_half);

    assign busy = (state != IDLE);
    assign mosi = (state != IDLE) ? (lsb_lat ? tx_sr[0] : tx_sr[DATA_WIDTH-1]) : 1'b0;

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if ((state != IDLE) && (cs_lat == CSW'(i))) cs_n[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (cnt_end) state_nxt = XFER;
            XFER:    if (cnt_end && last_half) state_nxt = HOLD;
            HOLD:    if (cnt_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            hcnt     <= '0;
            sclk     <= 1'b0;
            cpol_lat <= 1'b0;
            cpha_lat <= 1'b0;
            lsb_lat  <= 1'b0;
            cs_lat   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= finish;
            err  <= reject;
            if ((state == IDLE) || cnt_end) cnt <= '0;
            else                            cnt <= cnt + CNT_W'(1);
            if (state != XFER)  hcnt <= '0;
            else if (cnt_end)   hcnt <= last_half ? '0 : hcnt + HW'(1);
            if (accept) begin
                sclk     <= mode[1];
                cpol_lat <= mode[1];
                cpha_lat <= mode[0];
                lsb_lat  <= lsb_first;
                cs_lat   <= cs_sel;
            end else if (edge_tick) begin
                sclk <= ~sclk;
            end
            if (finish) rx_data <= rx_sr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)        tx_sr <= tx_data;
        else if (shift_en) tx_sr <= lsb_lat ? (tx_sr >> 1) : (tx_sr << 1);
        if (sample_en) begin
            rx_sr <= lsb_lat ? {miso, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Randomized bench for spi_master_mc: a behavioural SPI slave plus a transaction queue
// predict mosi word, rx_data, timing, select pattern and error/reset behaviour.
module tb_spi_master_mc;
    localparam int DW   = 8;
    localparam int NCS  = 5;
    localparam int CDIV = 5;
    localparam int CSW  = 3;
    localparam int LAT  = 1 + CDIV * (2 * DW + 2);
    localparam int XCYC = LAT - 1;
    localparam logic [NCS-1:0] CS_IDLE = '1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [DW-1:0]  tx_data = '0;
    logic [CSW-1:0] cs_sel = '0;
    logic [1:0]     mode = 2'b00;
    logic           lsb_first = 1'b0;
    logic           miso = 1'b0;
    logic           sclk, mosi, busy, done, err;
    logic [NCS-1:0] cs_n;
    logic [DW-1:0]  rx_data;

    spi_master_mc #(.DATA_WIDTH(DW), .NUM_CS(NCS), .CLK_DIV(CDIV)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
        .mode(mode), .lsb_first(lsb_first), .miso(miso), .sclk(sclk), .mosi(mosi),
        .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] sw;
        int            cs;
        logic [1:0]    md;
        bit            lsb;
        int            acc;
    } txn_t;

    txn_t expq[$];
    txn_t cur, e_done;
    int checks = 0, errors = 0;
    int edge_cnt = 0, done_cnt = 0, err_cnt = 0;
    int s_lead, s_trail, s_k, s_nsamp, cs_cnt, busy_cnt;
    logic [DW-1:0] s_got;
    bit   cs_act, cs_prev = 1'b0;
    logic sclk_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic bit_of(input logic [DW-1:0] w, input int k, input bit lsb);
        return lsb ? w[k] : w[DW-1-k];
    endfunction

    function automatic logic [NCS-1:0] cs_pat(input int cs);
        logic [NCS-1:0] p;
        p = '1;
        p[cs] = 1'b0;
        return p;
    endfunction

    // Monitor and slave model, evaluated 1ns after every rising edge.
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        if (err) err_cnt++;
        if (done) begin
            done_cnt++;
            if (expq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e_done = expq.pop_front();
                chk("rx_data", rx_data, e_done.sw);
                chk("mosi_word", s_got, e_done.tx);
                chk("latency", edge_cnt - e_done.acc, LAT);
                chk("lead_edges", s_lead, DW);
                chk("trail_edges", s_trail, DW);
                chk("cs_low_cycles", cs_cnt, XCYC);
                chk("busy_cycles", busy_cnt, XCYC);
                chk("done_busy", busy, 0);
                chk("done_cs_n", cs_n, CS_IDLE);
                chk("idle_sclk", sclk, e_done.md[1]);
                chk("idle_mosi", mosi, 0);
            end
        end
        cs_act = (cs_n !== CS_IDLE);
        if (cs_act && !cs_prev) begin
            s_lead = 0; s_trail = 0; s_k = 0; s_nsamp = 0; s_got = '0;
            cs_cnt = 0; busy_cnt = 0;
            if (expq.size() > 0) cur = expq[0];
            if (!cur.md[0]) chk("first_bit", mosi, bit_of(cur.tx, 0, cur.lsb));
        end else if (cs_act && (sclk !== sclk_prev)) begin
            if (sclk !== cur.md[1]) begin
                s_lead++;
                if (cur.md[0] && s_lead > 1) s_k++;
            end else begin
                s_trail++;
                if (!cur.md[0]) s_k++;
            end
            if ((sclk !== cur.md[1]) == !cur.md[0]) begin
                if (s_nsamp < DW) begin
                    if (cur.lsb) s_got[s_nsamp] = mosi;
                    else         s_got[DW-1-s_nsamp] = mosi;
                end
                s_nsamp++;
            end
        end
        if (cs_act && (cs_n === cs_pat(cur.cs))) cs_cnt++;
        if (busy) busy_cnt++;
        miso = (cs_act && s_k < DW) ? bit_of(cur.sw, s_k, cur.lsb) : 1'b0;
        cs_prev = cs_act;
        sclk_prev = sclk;
    end

    task automatic drive(input logic [DW-1:0] tx, input int cs, input logic [1:0] md, input bit lsb);
        tx_data = tx;
        cs_sel = cs[CSW-1:0];
        mode = md;
        lsb_first = lsb;
    endtask

    task automatic drive_junk();
        drive(DW'($urandom_range(0, 255)), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    task automatic run_txn(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input int cs,
                           input logic [1:0] md, input bit lsb, input int poke_at);
        txn_t t;
        int d0, e0;
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        drive(tx, cs, md, lsb);
        start = 1'b1;
        t.tx = tx; t.sw = sw; t.cs = cs; t.md = md; t.lsb = lsb; t.acc = edge_cnt;
        expq.push_back(t);
        @(negedge clk);
        start = 1'b0;
        drive_junk();
        if (poke_at > 0) begin
            repeat (poke_at) @(negedge clk);
            drive_junk();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(d0 + 1);
        chk("no_err_in_xfer", err_cnt - e0, 0);
    endtask

    task automatic run_bad(input int cs);
        int d0, e0;
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        drive(DW'($urandom_range(0, 255)), cs, 2'($urandom_range(0, 3)), 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_cs_n", cs_n, CS_IDLE);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        repeat (20) @(negedge clk);
        chk("err_no_done", done_cnt - d0, 0);
        chk("err_count", err_cnt - e0, 1);
    endtask

    task automatic run_b2b();
        txn_t t1, t2;
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        drive(8'h11, 1, 2'b00, 1'b0);
        start = 1'b1;
        t1.tx = 8'h11; t1.sw = 8'h77; t1.cs = 1; t1.md = 2'b00; t1.lsb = 1'b0; t1.acc = edge_cnt;
        t2.tx = 8'h22; t2.sw = 8'h99; t2.cs = 3; t2.md = 2'b11; t2.lsb = 1'b1; t2.acc = edge_cnt + LAT;
        expq.push_back(t1);
        expq.push_back(t2);
        @(negedge clk);
        drive(8'h22, 3, 2'b11, 1'b1);
        while (edge_cnt < t1.acc + LAT + 1) @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 2);
    endtask

    task automatic run_abort();
        txn_t t;
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        drive(8'hC3, 0, 2'b10, 1'b0);
        start = 1'b1;
        t.tx = 8'hC3; t.sw = 8'h0F; t.cs = 0; t.md = 2'b10; t.lsb = 1'b0; t.acc = edge_cnt;
        expq.push_back(t);
        @(negedge clk);
        start = 1'b0;
        repeat (38) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", cs_n, CS_IDLE);
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_rx", rx_data, 0);
        rst = 1'b0;
        expq.delete();
        repeat (100) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, CS_IDLE);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rx", rx_data, 0);
        rst = 1'b0;

        run_txn(8'hA5, 8'h3C, 2, 2'b00, 1'b0, 0);
        for (int m = 0; m < 4; m++) begin
            run_txn(8'h81, DW'($urandom_range(0, 255)), $urandom_range(0, NCS - 1), 2'(m), 1'b1, 0);
        end
        run_bad(5);
        run_bad(7);
        run_txn(8'h3E, 8'h5A, 4, 2'b01, 1'b0, 30);
        run_b2b();
        run_abort();
        run_txn(8'h6B, 8'hD2, 3, 2'b11, 1'b0, 0);

        @(negedge clk);
        rst = 1'b1;
        drive(8'h55, 1, 2'b00, 1'b0);
        start = 1'b1;
        @(negedge clk);
        chk("rst_wins_busy", busy, 0);
        chk("rst_wins_cs_n", cs_n, CS_IDLE);
        rst = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cs = $urandom_range(0, 7);
            if (cs >= NCS) run_bad(cs);
            else run_txn(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), cs,
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 1) == 1) ? $urandom_range(1, 80) : 0);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
